// File: rtl/wino_tile_scheduler.sv
// Winograd layer-pass scheduler: walks output-channel pairs by tile blocks, issues tile-buffer reads and
// aligns PE-array valids. Optional macro SCHED_PERF_CNT_EN adds a stall-cycle counter output.
module wino_tile_scheduler #(
  parameter int ADDR_W  = 8,
  parameter int OD_W    = 8,
  parameter int PE_ROWS = 4,
  parameter int PE_COLS = 4,
  parameter int RD_LAT  = 1,
  parameter int PE_LAT  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] block_cnt_i,
  input  logic [OD_W-1:0]   od_num_i,
  input  logic              size_type_i,
  input  logic              stall_i,
  output logic              data_rd_en_o,
  output logic [ADDR_W-1:0] data_rd_addr_o,
  output logic              weight_rd_en_o,
  output logic [OD_W-1:0]   weight_rd_addr_o,
  output logic              data_valid_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic              weight_valid_o,
  output logic [OD_W-1:0]   weight_od_o,
  output logic              size_type_o,
  output logic [ADDR_W-1:0] block_cnt_o,
  output logic              busy_o,
`ifdef SCHED_PERF_CNT_EN
  output logic [15:0]       stall_cycles_o,
`endif
  output logic              done_o
);

  localparam int DRAIN_LEN = RD_LAT + PE_LAT + PE_ROWS + PE_COLS - 2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   blk_q;
  logic [OD_W-1:0]     od_q;
  logic [ADDR_W-1:0]   block_cnt_q;
  logic [OD_W-1:0]     od_num_q;
  logic                size_type_q;
  logic                empty_q;
  logic [15:0]         drain_q;

  logic                start_acc;
  logic                issue_fire;
  logic                blk_last;
  logic                pair_last;
  logic                last_issue;
  logic [OD_W:0]       od_next_w;

  // The extra od bit keeps od+2 from wrapping when od_num is near 2^OD_W.
  assign start_acc  = (state_q == S_IDLE) && start_i;
  assign issue_fire = (state_q == S_ISSUE) && !empty_q && !stall_i;
  assign blk_last   = (blk_q == block_cnt_q - ADDR_W'(1));
  assign od_next_w  = {1'b0, od_q} + (OD_W+1)'(2);
  assign pair_last  = (od_next_w >= {1'b0, od_num_q});
  assign last_issue = issue_fire && blk_last && pair_last;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_ISSUE;
      S_ISSUE: begin
        if (empty_q)         state_d = S_DONE;
        else if (last_issue) state_d = S_DRAIN;
      end
      S_DRAIN: if (drain_q == 16'd1) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    data_rd_en_o     = issue_fire;
    weight_rd_en_o   = issue_fire;
    data_rd_addr_o   = issue_fire ? blk_q : '0;
    weight_rd_addr_o = issue_fire ? od_q  : '0;
    busy_o           = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    done_o           = (state_q == S_DONE);
  end

  // Pass configuration and (blk, od) walk
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_q       <= '0;
      od_q        <= '0;
      block_cnt_q <= '0;
      od_num_q    <= '0;
      size_type_q <= 1'b0;
      empty_q     <= 1'b0;
      drain_q     <= '0;
    end else begin
      if (start_acc) begin
        blk_q       <= '0;
        od_q        <= '0;
        block_cnt_q <= block_cnt_i;
        od_num_q    <= od_num_i;
        size_type_q <= size_type_i;
        empty_q     <= (block_cnt_i == '0) || (od_num_i == '0);
      end else if (issue_fire) begin
        if (blk_last) begin
          blk_q <= '0;
          if (!pair_last) od_q <= od_next_w[OD_W-1:0];
        end else begin
          blk_q <= blk_q + ADDR_W'(1);
        end
      end
      if (last_issue)                drain_q <= 16'(DRAIN_LEN);
      else if (state_q == S_DRAIN)   drain_q <= drain_q - 16'd1;
    end
  end

  assign size_type_o = size_type_q;
  assign block_cnt_o = block_cnt_q;

  logic [RD_LAT-1:0] vld_p0;
  logic [ADDR_W-1:0] daddr_p0 [RD_LAT];
  logic [OD_W-1:0]   wod_p0   [RD_LAT];

  // Read-latency delay line; invalid slots carry zero addresses
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        vld_p0[i]   <= 1'b0;
        daddr_p0[i] <= '0;
        wod_p0[i]   <= '0;
      end
    end else begin
      vld_p0[0]   <= data_rd_en_o;
      daddr_p0[0] <= data_rd_addr_o;
      wod_p0[0]   <= weight_rd_addr_o;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_p0[i]   <= vld_p0[i-1];
        daddr_p0[i] <= daddr_p0[i-1];
        wod_p0[i]   <= wod_p0[i-1];
      end
    end
  end

  assign data_valid_o   = vld_p0[RD_LAT-1];
  assign weight_valid_o = vld_p0[RD_LAT-1];
  assign data_addr_o    = daddr_p0[RD_LAT-1];
  assign weight_od_o    = wod_p0[RD_LAT-1];

`ifdef SCHED_PERF_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset || start_acc)
      stall_cnt_q <= '0;
    else if ((state_q == S_ISSUE) && stall_i && (stall_cnt_q != 16'hFFFF))
      stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign stall_cycles_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_wino_tile_scheduler.sv
// Directed bench for wino_tile_scheduler (default parameters, RD_LAT=1, drain length 10).
module tb_wino_tile_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_i;
  logic [7:0] block_cnt_i;
  logic [7:0] od_num_i;
  logic       size_type_i;
  logic       stall_i;
  logic       data_rd_en_o, weight_rd_en_o, data_valid_o, weight_valid_o;
  logic [7:0] data_rd_addr_o, weight_rd_addr_o, data_addr_o, weight_od_o, block_cnt_o;
  logic       size_type_o, busy_o, done_o;
`ifdef SCHED_PERF_CNT_EN
  logic [15:0] stall_cycles_o;
`endif

  int errors = 0;
  int checks = 0;
  int first_cyc [8];

  wino_tile_scheduler dut (
    .clk(clk), .reset(reset), .start_i(start_i), .block_cnt_i(block_cnt_i),
    .od_num_i(od_num_i), .size_type_i(size_type_i), .stall_i(stall_i),
    .data_rd_en_o(data_rd_en_o), .data_rd_addr_o(data_rd_addr_o),
    .weight_rd_en_o(weight_rd_en_o), .weight_rd_addr_o(weight_rd_addr_o),
    .data_valid_o(data_valid_o), .data_addr_o(data_addr_o),
    .weight_valid_o(weight_valid_o), .weight_od_o(weight_od_o),
    .size_type_o(size_type_o), .block_cnt_o(block_cnt_o), .busy_o(busy_o),
`ifdef SCHED_PERF_CNT_EN
    .stall_cycles_o(stall_cycles_o),
`endif
    .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    logic [63:0] got;
    got = {data_rd_en_o, weight_rd_en_o, data_valid_o, weight_valid_o, size_type_o, busy_o, done_o,
           data_rd_addr_o, weight_rd_addr_o, data_addr_o, weight_od_o, block_cnt_o};
    checks++;
    if (got !== 64'd0) begin
      errors++;
      $display("FAIL %s: outputs=%h required all zero", tag, got);
    end
  endtask

  // Runs one pass; expected issue order is the nested (od step 2, blk) walk.
  task automatic pass_check(input string tag, input int bc, input int on, input logic st,
                            input int stall_a, input int stall_b, input int restart_at,
                            input int exp_done, input int exp_issues);
    int issues = 0, order_bad = 0, align_bad = 0, busy_bad = 0, stall_bad = 0;
    int done_cyc = -1, done_cnt = 0;
    int eb = 0, eo = 0;
    logic pe = 1'b0;
    logic [7:0] pa = 8'd0, po = 8'd0;
    for (int i = 0; i < 8; i++) first_cyc[i] = -1;
    block_cnt_i = 8'(bc); od_num_i = 8'(on); size_type_i = st; start_i = 1'b1; stall_i = 1'b0;
    for (int c = 1; c <= exp_done + 2; c++) begin
      tick();
      start_i = (c == restart_at);
      stall_i = (c >= stall_a) && (c <= stall_b);
      #1;
      if (c == 1) begin
        checks++;
        if (block_cnt_o !== 8'(bc) || size_type_o !== st) begin
          errors++;
          $display("FAIL %s latch: block_cnt_o=%0d size_type_o=%0b required %0d %0b",
                   tag, block_cnt_o, size_type_o, bc, st);
        end
      end
      if (stall_i && data_rd_en_o) stall_bad++;
      if (data_rd_en_o !== weight_rd_en_o) order_bad++;
      if (data_rd_en_o === 1'b1) begin
        if (issues < 8) first_cyc[issues] = c;
        if (data_rd_addr_o !== 8'(eb) || weight_rd_addr_o !== 8'(eo)) begin
          if (order_bad == 0)
            $display("FAIL %s order: issue %0d got (%0d,%0d) required (%0d,%0d)",
                     tag, issues, data_rd_addr_o, weight_rd_addr_o, eb, eo);
          order_bad++;
        end
        issues++;
        eb++;
        if (eb == bc) begin eb = 0; eo += 2; end
      end
      if (data_valid_o !== pe || weight_valid_o !== pe ||
          data_addr_o !== (pe ? pa : 8'd0) || weight_od_o !== (pe ? po : 8'd0)) align_bad++;
      pe = data_rd_en_o;
      pa = data_rd_addr_o;
      po = weight_rd_addr_o;
      if (done_o === 1'b1) begin
        if (done_cyc < 0) done_cyc = c;
        done_cnt++;
      end
      if (busy_o !== (c < exp_done)) busy_bad++;
    end
    start_i = 1'b0;
    stall_i = 1'b0;
    checks++;
    if (issues != exp_issues) begin
      errors++; $display("FAIL %s issues: got %0d required %0d", tag, issues, exp_issues);
    end
    checks++;
    if (order_bad != 0) begin
      errors++; $display("FAIL %s order: %0d bad issue cycles, required 0", tag, order_bad);
    end
    checks++;
    if (align_bad != 0) begin
      errors++; $display("FAIL %s valid_align: %0d bad cycles, required 0", tag, align_bad);
    end
    checks++;
    if (stall_bad != 0) begin
      errors++; $display("FAIL %s stall_block: %0d stalled issues, required 0", tag, stall_bad);
    end
    checks++;
    if (done_cyc != exp_done || done_cnt != 1) begin
      errors++;
      $display("FAIL %s done: first at T+%0d count %0d, required T+%0d count 1",
               tag, done_cyc, done_cnt, exp_done);
    end
    checks++;
    if (busy_bad != 0) begin
      errors++; $display("FAIL %s busy: %0d bad cycles, required 0", tag, busy_bad);
    end
    checks++;
    if (block_cnt_o !== 8'(bc) || size_type_o !== st) begin
      errors++;
      $display("FAIL %s hold: block_cnt_o=%0d size_type_o=%0b required %0d %0b",
               tag, block_cnt_o, size_type_o, bc, st);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start_i = 1'b0; stall_i = 1'b0;
    block_cnt_i = 8'd0; od_num_i = 8'd0; size_type_i = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset_state");
    reset = 1'b0;
    tick();
    check_idle_outputs("idle_after_reset");
  endtask

  task automatic test_basic();
    pass_check("basic", 3, 4, 1'b1, 0, -1, 0, 17, 6);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (first_cyc[i] != i + 1) begin
        errors++; $display("FAIL basic issue_cycle[%0d]: T+%0d required T+%0d", i, first_cyc[i], i + 1);
      end
    end
  endtask

  task automatic test_stall();
    int exp_c [6] = '{1, 2, 5, 6, 7, 8};
    pass_check("stall", 3, 4, 1'b0, 3, 4, 0, 19, 6);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (first_cyc[i] != exp_c[i]) begin
        errors++; $display("FAIL stall issue_cycle[%0d]: T+%0d required T+%0d", i, first_cyc[i], exp_c[i]);
      end
    end
`ifdef SCHED_PERF_CNT_EN
    checks++;
    if (stall_cycles_o !== 16'd2) begin
      errors++; $display("FAIL stall_cycles: got %0d required 2", stall_cycles_o);
    end
`endif
  endtask

  task automatic test_zero_size();
    pass_check("zero_blk", 0, 8, 1'b1, 0, -1, 0, 2, 0);
    pass_check("zero_od", 5, 0, 1'b0, 0, -1, 0, 2, 0);
  endtask

  task automatic test_odd_od_restart();
    pass_check("odd_od", 1, 3, 1'b1, 0, -1, 3, 13, 2);
    checks++;
    if (first_cyc[0] != 1 || first_cyc[1] != 2 || first_cyc[2] != -1) begin
      errors++;
      $display("FAIL odd_od cycles: %0d %0d %0d required 1 2 -1", first_cyc[0], first_cyc[1], first_cyc[2]);
    end
  endtask

  task automatic test_reset_mid_pass();
    int dones = 0;
    block_cnt_i = 8'd4; od_num_i = 8'd4; size_type_i = 1'b1; start_i = 1'b1;
    tick(); start_i = 1'b0;
    tick();
    checks++;
    if (data_rd_en_o !== 1'b1 || data_rd_addr_o !== 8'd1) begin
      errors++; $display("FAIL midreset second_issue: en=%0b addr=%0d required 1 1", data_rd_en_o, data_rd_addr_o);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_idle_outputs("midreset_clear");
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done_o === 1'b1 || busy_o === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++; $display("FAIL midreset no_done: %0d active cycles, required 0", dones);
    end
    pass_check("after_reset", 2, 2, 1'b0, 0, -1, 0, 13, 2);
  endtask

  task automatic test_large();
    pass_check("large", 255, 255, 1'b0, 0, -1, 0, 1 + 32640 + 10, 32640);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_size();
    test_odd_od_restart();
    test_reset_mid_pass();
    test_large();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
